// File: rtl/ice_status_pkg.sv
// Shared types, frame constants and the byte-wide CRC-16/CCITT-FALSE update
// used by the iCE status frame parser.
package ice_status_pkg;

  localparam logic [7:0]  SYNC_BYTE           = 8'hA5;
  localparam int unsigned FRAME_PAYLOAD_BYTES = 16;
  localparam logic [15:0] CRC_INIT            = 16'hFFFF;
  localparam logic [15:0] CRC_POLY            = 16'h1021;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned PAYLOAD_W = FRAME_PAYLOAD_BYTES * 8;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_ID,
    ST_PAYLOAD,
    ST_CRC_HI,
    ST_CRC_LO
  } parser_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_state_e;

  // Payload words in wire order; the first byte received lands in pos0[31:24]
  typedef struct packed {
    logic signed [WORD_W-1:0] pos0;
    logic signed [WORD_W-1:0] pos1;
    logic signed [WORD_W-1:0] vel0;
    logic signed [WORD_W-1:0] vel1;
  } enc_payload_t;

  function automatic logic [15:0] crc16_update(input logic [15:0] crc,
                                               input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else       c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/ice_uart_rx.sv
// UART 8N1 receiver: 2-FF synchroniser, falling-edge start detect with
// mid-bit recheck, LSB-first mid-bit sampling, stop-bit framing check.
module ice_uart_rx
  import ice_status_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUDRATE      = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned BIT_CLKS  = CLOCK_FREQ_HZ / BAUDRATE;
  localparam int unsigned HALF_CLKS = BIT_CLKS / 2;
  localparam int unsigned CNT_W     = $clog2(BIT_CLKS + 1);

  uart_state_e      r_state;
  uart_state_e      w_next;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_rx_d;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             w_fall;
  logic             w_half_end;
  logic             w_bit_end;
  logic             w_byte_valid_c;
  logic             w_frame_err_c;

  assign w_fall     = r_rx_d & ~r_sync2;
  assign w_half_end = (r_cnt == CNT_W'(HALF_CLKS - 1));
  assign w_bit_end  = (r_cnt == CNT_W'(BIT_CLKS - 1));

  // Line idles high, so the synchroniser resets to 1 to avoid a false start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= RX_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_next = RX_START;
      RX_START: if (w_half_end) w_next = r_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_bit_end && (r_bit == 3'd7)) w_next = RX_STOP;
      RX_STOP:  if (w_bit_end) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  always_comb begin
    w_byte_valid_c = 1'b0;
    w_frame_err_c  = 1'b0;
    if ((r_state == RX_STOP) && w_bit_end) begin
      w_byte_valid_c = r_sync2;
      w_frame_err_c  = ~r_sync2;
    end
  end

  // Bit timer restarts on every state change and after each data sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= w_byte_valid_c;
      frame_err  <= w_frame_err_c;
      if (w_byte_valid_c) byte_data <= r_shift;

      if ((r_state == RX_IDLE) || (r_state != w_next) ||
          ((r_state == RX_DATA) && w_bit_end))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CNT_W'(1);

      if (r_state == RX_START) r_bit <= '0;
      if ((r_state == RX_DATA) && w_bit_end) begin
        r_shift <= {r_sync2, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
    end
  end

endmodule

// File: rtl/ice_status_parser.sv
// Parses 20-byte iCE motor status frames from a UART line into encoder outputs.
// Define ICE_STATUS_CRC_EN to check the CRC; otherwise CRC bytes are consumed unchecked.
module ice_status_parser
  import ice_status_pkg::*;
#(
  parameter int unsigned NUMBER_OF_MOTORS = 6,
  parameter int unsigned CLOCK_FREQ_HZ    = 50_000_000,
  parameter int unsigned BAUDRATE         = 115200,
  parameter int unsigned TIMEOUT_BITS     = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_i,
  output logic                     status_valid,
  output logic [7:0]               status_motor,
  output logic signed [WORD_W-1:0] encoder0_position,
  output logic signed [WORD_W-1:0] encoder1_position,
  output logic signed [WORD_W-1:0] encoder0_velocity,
  output logic signed [WORD_W-1:0] encoder1_velocity,
  output logic [WORD_W-1:0]        good_frames,
  output logic [WORD_W-1:0]        crc_errors
);

  localparam int unsigned BIT_CLKS     = CLOCK_FREQ_HZ / BAUDRATE;
  localparam int unsigned TIMEOUT_CLKS = TIMEOUT_BITS * BIT_CLKS;
  localparam int unsigned GAP_W        = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned BCNT_W       = $clog2(FRAME_PAYLOAD_BYTES);
  localparam logic [WORD_W-1:0] CNT_MAX = '1;

  logic [7:0]           w_byte_data;
  logic                 w_byte_valid;
  logic                 w_frame_err;
  parser_state_e        r_state;
  parser_state_e        w_next;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic                 w_timeout;
  logic [BCNT_W-1:0]    r_byte_cnt;
  logic [7:0]           r_id;
  logic [PAYLOAD_W-1:0] r_payload;
  enc_payload_t         w_payload;
  logic                 w_frame_done;
  logic                 w_crc_ok;
  logic                 w_id_ok;
  logic                 w_accept_c;
  logic                 w_crc_err_c;

  ice_uart_rx #(
    .CLOCK_FREQ_HZ(CLOCK_FREQ_HZ),
    .BAUDRATE     (BAUDRATE)
  ) u_uart_rx (
    .clk       (clk),
    .reset     (reset),
    .rx_i      (rx_i),
    .byte_data (w_byte_data),
    .byte_valid(w_byte_valid),
    .frame_err (w_frame_err)
  );

  assign w_payload    = r_payload;
  assign w_timeout    = (r_gap_cnt == GAP_W'(TIMEOUT_CLKS));
  assign w_frame_done = w_byte_valid && (r_state == ST_CRC_LO);
  assign w_id_ok      = (32'(r_id) < NUMBER_OF_MOTORS);

`ifdef ICE_STATUS_CRC_EN
  logic [15:0] r_crc;
  logic [7:0]  r_crc_hi;

  assign w_crc_ok = ({r_crc_hi, w_byte_data} == r_crc);

  // Running CRC over id and payload, seeded when the sync byte is seen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc    <= '0;
      r_crc_hi <= '0;
    end else if (w_byte_valid) begin
      case (r_state)
        ST_HUNT:    if (w_byte_data == SYNC_BYTE) r_crc <= CRC_INIT;
        ST_ID,
        ST_PAYLOAD: r_crc <= crc16_update(r_crc, w_byte_data);
        ST_CRC_HI:  r_crc_hi <= w_byte_data;
        default:    ;
      endcase
    end
  end
`else
  assign w_crc_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_HUNT;
    else       r_state <= w_next;
  end

  // A sync byte only matters in HUNT; elsewhere every byte is frame data
  always_comb begin
    w_next = r_state;
    if (w_frame_err) begin
      w_next = ST_HUNT;
    end else if (w_byte_valid) begin
      case (r_state)
        ST_HUNT:    if (w_byte_data == SYNC_BYTE) w_next = ST_ID;
        ST_ID:      w_next = ST_PAYLOAD;
        ST_PAYLOAD: if (r_byte_cnt == BCNT_W'(FRAME_PAYLOAD_BYTES - 1)) w_next = ST_CRC_HI;
        ST_CRC_HI:  w_next = ST_CRC_LO;
        ST_CRC_LO:  w_next = ST_HUNT;
        default:    w_next = ST_HUNT;
      endcase
    end else if (w_timeout) begin
      w_next = ST_HUNT;
    end
  end

  // CRC failure takes precedence over an out-of-range id
  always_comb begin
    w_accept_c  = 1'b0;
    w_crc_err_c = 1'b0;
    if (w_frame_done) begin
      if (!w_crc_ok)    w_crc_err_c = 1'b1;
      else if (w_id_ok) w_accept_c  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gap_cnt  <= '0;
      r_byte_cnt <= '0;
      r_id       <= '0;
      r_payload  <= '0;
    end else begin
      if (w_byte_valid || w_frame_err || (r_state == ST_HUNT))
        r_gap_cnt <= '0;
      else if (!w_timeout)
        r_gap_cnt <= r_gap_cnt + GAP_W'(1);

      if (w_byte_valid) begin
        case (r_state)
          ST_ID: begin
            r_id       <= w_byte_data;
            r_byte_cnt <= '0;
          end
          ST_PAYLOAD: begin
            r_payload  <= {r_payload[PAYLOAD_W-9:0], w_byte_data};
            r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Published status and saturating event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_valid      <= 1'b0;
      status_motor      <= '0;
      encoder0_position <= '0;
      encoder1_position <= '0;
      encoder0_velocity <= '0;
      encoder1_velocity <= '0;
      good_frames       <= '0;
      crc_errors        <= '0;
    end else begin
      status_valid <= w_accept_c;
      if (w_accept_c) begin
        status_motor      <= r_id;
        encoder0_position <= w_payload.pos0;
        encoder1_position <= w_payload.pos1;
        encoder0_velocity <= w_payload.vel0;
        encoder1_velocity <= w_payload.vel1;
        if (good_frames != CNT_MAX) good_frames <= good_frames + 32'd1;
      end
      if (w_crc_err_c && (crc_errors != CNT_MAX)) crc_errors <= crc_errors + 32'd1;
    end
  end

endmodule

// File: tb/tb_ice_status_parser.sv
// Directed bench for ice_status_parser: serialises frames onto rx_i and checks
// outputs every cycle against a frame-level model, plus hand-computed literals.
module tb_ice_status_parser;
  import ice_status_pkg::*;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 60_000;
  localparam int unsigned BIT    = CLK_HZ / BAUD;
  localparam int unsigned NMOT   = 6;
`ifdef ICE_STATUS_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0]  motor;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [31:0] v0;
    logic [31:0] v1;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_i;
  logic        status_valid;
  logic [7:0]  status_motor;
  logic signed [31:0] encoder0_position;
  logic signed [31:0] encoder1_position;
  logic signed [31:0] encoder0_velocity;
  logic signed [31:0] encoder1_velocity;
  logic [31:0] good_frames;
  logic [31:0] crc_errors;

  exp_t        exp_arr [32];
  int          wr_idx;
  int          rd_idx;
  exp_t        mdl;
  logic [31:0] mdl_good;
  logic [31:0] mdl_crcerr;
  bit          crc_window;
  int          total;
  int          bad;
  logic [7:0]  frm [20];

  ice_status_parser #(
    .NUMBER_OF_MOTORS(NMOT),
    .CLOCK_FREQ_HZ   (CLK_HZ),
    .BAUDRATE        (BAUD),
    .TIMEOUT_BITS    (20)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_i             (rx_i),
    .status_valid     (status_valid),
    .status_motor     (status_motor),
    .encoder0_position(encoder0_position),
    .encoder1_position(encoder1_position),
    .encoder0_velocity(encoder0_velocity),
    .encoder1_velocity(encoder1_velocity),
    .good_frames      (good_frames),
    .crc_errors       (crc_errors)
  );

  always #5 clk = ~clk;

  // Bit-serial reference CRC, MSB first
  function automatic logic [15:0] model_crc(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = d[i] ^ c[15];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, want);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rx_i = 1'b1;
    wait_clks(n * int'(BIT));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_i = 1'b0;
    wait_clks(int'(BIT));
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      wait_clks(int'(BIT));
    end
    rx_i = stop_bit;
    wait_clks(int'(BIT));
  endtask

  task automatic build_frame(input logic [7:0] id, input logic [31:0] p0, input logic [31:0] p1,
                             input logic [31:0] v0, input logic [31:0] v1);
    logic [31:0] w [4];
    logic [15:0] crc;
    w[0] = p0; w[1] = p1; w[2] = v0; w[3] = v1;
    frm[0] = 8'hA5;
    frm[1] = id;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        frm[2 + 4*k + j] = w[k][31 - 8*j -: 8];
    crc = 16'hFFFF;
    for (int i = 1; i < 18; i++) crc = model_crc(crc, frm[i]);
    frm[18] = crc[15:8];
    frm[19] = crc[7:0];
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) send_byte(frm[i], 1'b1);
  endtask

  // Classify the frame from the protocol rules, then put it on the line
  task automatic send_frame();
    logic [15:0] crc;
    bit          crc_bad;
    exp_t        e;
    crc = 16'hFFFF;
    for (int i = 1; i < 18; i++) crc = model_crc(crc, frm[i]);
    crc_bad = CRC_EN && (crc != {frm[18], frm[19]});
    if (!crc_bad && (int'(frm[1]) < int'(NMOT))) begin
      e.motor = frm[1];
      e.p0 = {frm[2],  frm[3],  frm[4],  frm[5]};
      e.p1 = {frm[6],  frm[7],  frm[8],  frm[9]};
      e.v0 = {frm[10], frm[11], frm[12], frm[13]};
      e.v1 = {frm[14], frm[15], frm[16], frm[17]};
      exp_arr[wr_idx % 32] = e;
      wr_idx++;
    end
    send_partial(19);
    crc_window = 1'b1;
    send_byte(frm[19], 1'b1);
    @(negedge clk);
    #1;
    if (crc_bad && (mdl_crcerr != 32'hFFFF_FFFF)) mdl_crcerr = mdl_crcerr + 32'd1;
    crc_window = 1'b0;
    check("status_valid_seen", 32'(rd_idx), 32'(wr_idx));
    idle_bits(2);
  endtask

  initial begin
    logic [7:0]  s [9];
    logic [15:0] c_mdl;
    logic [15:0] c_pkg;
    bit          ok;

    total = 0; bad = 0; wr_idx = 0; rd_idx = 0;
    mdl = '{8'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    mdl_good = '0; mdl_crcerr = '0; crc_window = 1'b0;
    reset = 1'b1;
    rx_i  = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (reset) begin
          mdl        = '{8'h0, 32'h0, 32'h0, 32'h0, 32'h0};
          mdl_good   = '0;
          mdl_crcerr = '0;
          rd_idx     = wr_idx;
        end else if (status_valid) begin
          if (rd_idx == wr_idx) begin
            total++;
            bad++;
            $display("FAIL spurious_status_valid: got=1 want=0");
          end else begin
            mdl = exp_arr[rd_idx % 32];
            rd_idx++;
            if (mdl_good != 32'hFFFF_FFFF) mdl_good = mdl_good + 32'd1;
          end
        end
        total++;
        ok = (status_motor == mdl.motor) && (encoder0_position == mdl.p0) &&
             (encoder1_position == mdl.p1) && (encoder0_velocity == mdl.v0) &&
             (encoder1_velocity == mdl.v1) && (good_frames == mdl_good) &&
             (crc_window || (crc_errors == mdl_crcerr));
        if (!ok) begin
          bad++;
          $display("FAIL outputs: got id=%h p0=%h p1=%h v0=%h v1=%h good=%0d crcerr=%0d want id=%h p0=%h p1=%h v0=%h v1=%h good=%0d crcerr=%0d",
                   status_motor, encoder0_position, encoder1_position, encoder0_velocity,
                   encoder1_velocity, good_frames, crc_errors, mdl.motor, mdl.p0, mdl.p1,
                   mdl.v0, mdl.v1, mdl_good, mdl_crcerr);
        end
      end
    join_none

    // Reset state
    wait_clks(5);
    check("rst_status_valid", 32'(status_valid), 32'd0);
    check("rst_motor", 32'(status_motor), 32'd0);
    check("rst_enc0_pos", encoder0_position, 32'd0);
    check("rst_good", good_frames, 32'd0);
    check("rst_crcerr", crc_errors, 32'd0);

    // CRC check value of "123456789"
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    c_mdl = 16'hFFFF;
    c_pkg = 16'hFFFF;
    for (int i = 0; i < 9; i++) begin
      c_mdl = model_crc(c_mdl, s[i]);
      c_pkg = crc16_update(c_pkg, s[i]);
    end
    check("model_crc_check", 32'(c_mdl), 32'h29B1);
    check("pkg_crc_check", 32'(c_pkg), 32'h29B1);

    reset = 1'b0;
    idle_bits(3);

    // Nominal frame
    build_frame(8'd2, 32'h0000_0064, 32'hFFFF_FF9C, 32'd5, 32'hFFFF_FFFB);
    send_frame();
    check("t1_motor", 32'(status_motor), 32'd2);
    check("t1_enc0_pos", encoder0_position, 32'd100);
    check("t1_enc1_pos", encoder1_position, 32'hFFFF_FF9C);
    check("t1_enc0_vel", encoder0_velocity, 32'd5);
    check("t1_enc1_vel", encoder1_velocity, 32'hFFFF_FFFB);
    check("t1_good", good_frames, 32'd1);
    check("t1_crcerr", crc_errors, 32'd0);

    // Corrupted CRC low byte
    frm[19] = frm[19] ^ 8'h01;
    send_frame();
    check("t2_crcerr", crc_errors, CRC_EN ? 32'd1 : 32'd0);
    check("t2_good", good_frames, CRC_EN ? 32'd1 : 32'd2);
    check("t2_enc0_pos", encoder0_position, 32'd100);

    // Out-of-range motor id with valid CRC
    build_frame(8'd6, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    send_frame();
    check("t3_good", good_frames, CRC_EN ? 32'd1 : 32'd2);
    check("t3_crcerr", crc_errors, CRC_EN ? 32'd1 : 32'd0);
    check("t3_motor", 32'(status_motor), 32'd2);

    // Sync byte value inside the payload is plain data
    build_frame(8'd0, 32'hA5A5_A5A5, 32'h0000_00A5, 32'h1234_5678, 32'hA500_0001);
    send_frame();
    check("t4_motor", 32'(status_motor), 32'd0);
    check("t4_enc0_pos", encoder0_position, 32'hA5A5_A5A5);
    check("t4_enc1_vel", encoder1_velocity, 32'hA500_0001);

    // Stall after 7 bytes, then a full frame
    build_frame(8'd3, 32'd7, 32'd8, 32'd9, 32'd10);
    send_partial(7);
    idle_bits(25);
    send_frame();
    check("t5_motor", 32'(status_motor), 32'd3);
    check("t5_enc1_vel", encoder1_velocity, 32'd10);

    // Framing error mid-frame, then a full frame
    build_frame(8'd4, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0001, 32'h8000_0000);
    send_partial(5);
    send_byte(8'h00, 1'b0);
    idle_bits(2);
    send_frame();
    check("t6_motor", 32'(status_motor), 32'd4);
    check("t6_enc0_pos", encoder0_position, 32'hDEAD_BEEF);

    // Reset at byte 10, then a full frame
    build_frame(8'd5, 32'd11, 32'd12, 32'd13, 32'd14);
    send_partial(10);
    wait_clks(3);
    reset = 1'b1;
    wait_clks(4);
    check("t7_rst_motor", 32'(status_motor), 32'd0);
    check("t7_rst_enc0_pos", encoder0_position, 32'd0);
    check("t7_rst_good", good_frames, 32'd0);
    check("t7_rst_crcerr", crc_errors, 32'd0);
    reset = 1'b0;
    idle_bits(2);
    build_frame(8'd1, 32'hFFFF_FFFF, 32'd0, 32'h7FFF_FFFF, 32'd2);
    send_frame();
    check("t7_good", good_frames, 32'd1);
    check("t7_motor", 32'(status_motor), 32'd1);
    check("t7_enc0_vel", encoder0_velocity, 32'h7FFF_FFFF);

    idle_bits(2);
    check("no_pending_frames", 32'(rd_idx), 32'(wr_idx));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ice_status_parser.md
ICE_STATUS_PARSER -- requirements
Module: ice_status_parser

Interface
REQ-001 SHALL have parameter NUMBER_OF_MOTORS, default 6: valid motor ids are 0..NUMBER_OF_MOTORS-1.
REQ-002 SHALL have parameter CLOCK_FREQ_HZ, default 50_000_000: clk frequency.
REQ-003 SHALL have parameter BAUDRATE, default 115200: UART bit rate.
REQ-004 SHALL have parameter TIMEOUT_BITS, default 20: maximum inter-byte gap in bit periods.
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port rx_i, input, 1: UART 8N1 serial line from the iCE board, idle high.
REQ-008 SHALL have port status_valid, output, 1: one-cycle strobe for an accepted frame.
REQ-009 SHALL have port status_motor, output, 8: motor id of the last accepted frame.
REQ-010 SHALL have ports encoder0_position, encoder1_position, encoder0_velocity, encoder1_velocity, output, signed 32 each: fields of the last accepted frame.
REQ-011 SHALL have ports good_frames and crc_errors, output, 32 each: saturating event counters.

Function
REQ-012 Frame format SHALL be 20 bytes: sync 0xA5, motor id, 16 payload bytes, then CRC high byte, CRC low byte.
REQ-013 Payload SHALL contain four 32-bit words, MSB first, in this order: pos0, pos1, vel0, vel1.
REQ-014 CRC SHALL be CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, no reflection, no xorout), computed over the id and payload bytes (17 bytes).
REQ-015 Parser states SHALL be HUNT, ID, PAYLOAD, CRC_HI, CRC_LO.
- HUNT->ID on byte 0xA5; other bytes are ignored.
- ID->PAYLOAD on any byte.
- PAYLOAD->CRC_HI after 16 bytes.
- CRC_HI->CRC_LO on any byte.
- CRC_LO->HUNT on any byte.
REQ-016 A 0xA5 byte received outside HUNT SHALL be treated as data; the parser SHALL NOT resync.
REQ-017 On CRC match with id < NUMBER_OF_MOTORS, all outputs SHALL update and status_valid SHALL pulse exactly one clk after the CRC_LO byte strobe; good_frames SHALL increment.
REQ-018 On CRC mismatch, outputs SHALL hold, status_valid SHALL stay 0, and crc_errors SHALL increment.
REQ-019 A frame with id >= NUMBER_OF_MOTORS and a valid CRC SHALL be silently dropped; no counter changes.
REQ-020 Counters SHALL saturate at 0xFFFFFFFF.
REQ-021 If the gap between bytes exceeds TIMEOUT_BITS bit periods in any state other than HUNT, the parser SHALL return to HUNT with no counter change.
REQ-022 UART reception SHALL:
- synchronise rx_i through 2 flip-flops;
- detect the start bit on a falling edge and recheck it at mid-bit;
- sample data LSB first at mid-bit, with bit period CLOCK_FREQ_HZ/BAUDRATE clks (integer division).
REQ-023 A stop bit sampled as 0 SHALL discard that byte and force the parser to HUNT.

Reset
REQ-024 On reset, state SHALL be HUNT, and all outputs, counters and the CRC register SHALL be 0, with status_valid=0.
REQ-025 A reset asserted mid-frame SHALL abandon the frame; the first frame after reset deassertion SHALL be parsed normally.

Configuration
REQ-026 With ICE_STATUS_CRC_EN defined, CRC SHALL be checked per REQ-017/018.
REQ-027 Without ICE_STATUS_CRC_EN, the CRC bytes SHALL still be consumed, every in-range frame SHALL be accepted, and crc_errors SHALL remain 0; no CRC logic SHALL be instantiated.

Structure
REQ-028 A shared package ice_status_pkg SHALL hold:
- the parser state enum;
- SYNC_BYTE=8'hA5, FRAME_PAYLOAD_BYTES=16, CRC_INIT=16'hFFFF, CRC_POLY=16'h1021.
REQ-029 One sub-module, ice_uart_rx, SHALL implement REQ-022/023 and output byte_data[7:0], a one-cycle byte_valid and a one-cycle frame_err.
REQ-030 The CRC update SHALL be a byte-wide combinational function in the package, not a module.

Verification
REQ-031 Frame id=2, pos0=0x00000064, pos1=0xFFFFFF9C, vel0=5, vel1=-5, correct CRC -> status_valid once; status_motor=2; encoder0_position=100, encoder1_position=-100; good_frames=1.
REQ-032 Same frame with the CRC low byte XOR 0x01 -> no status_valid; outputs unchanged; crc_errors=1; with the macro undefined -> accepted and crc_errors=0.
REQ-033 CRC function fed ASCII "123456789" -> 0x29B1.
REQ-034 Frame stalled after 7 bytes for 25 bit periods, then a full valid frame -> exactly one status_valid, for the second frame only.
REQ-035 Valid frame with id=6 (NUMBER_OF_MOTORS=6) -> no status_valid and both counters unchanged.
REQ-036 Cases:
- a byte with stop bit 0 mid-frame -> HUNT, no outputs, then the next valid frame is accepted;
- reset pulsed at byte 10 -> all outputs 0 and the next frame is accepted.
